mar_ir_unit: RTL and testbench
==============================

Name: mar_ir_unit

Overview:
- Address-path front end of the CPU datapath: an 8-bit Instruction Register (IR) and an 8-bit Memory Address Register (MAR).
- IR captures instruction words from result bus busC and decodes the opcode field.
- MAR captures either busC or the IR operand field, and drives the memory address bus bus_dir.
- Sits between the ALU/result bus and the memory address port; the opcode output feeds the control unit.

Parameters:
- DATA_W, 8, width of busC, IR, MAR and bus_dir.
- OPCODE_W, 5, width of the opcode field, taken from the IR MSBs; operand field width is DATA_W-OPCODE_W (3).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  reset; asynchronous, active-low. One clock domain only.
- ena_ir  input  1  IR load enable.
- sel_ir  input  1  MAR source select: 0 = busC, 1 = IR operand field.
- hmar  input  1  MAR load enable.
- busC  input  DATA_W  result bus data.
- opcode  output  OPCODE_W  IR[DATA_W-1 : DATA_W-OPCODE_W].
- bus_dir  output  DATA_W  memory address; equals MAR.

Behaviour:
- Reset: rst low clears IR and MAR to 0 immediately, with no clock needed. opcode=0 and bus_dir=0 while rst is low. Loads resume on the first rising edge after rst returns high.
- IR: on a rising edge with ena_ir=1, IR<=busC. With ena_ir=0, IR holds, regardless of busC activity.
- opcode is combinational from the IR register: no decode logic and no extra latency. It is valid in the cycle after the load edge.
- MAR on a rising edge with hmar=1:
  - sel_ir=0: MAR<=busC.
  - sel_ir=1: MAR<={zeros, IR[DATA_W-OPCODE_W-1:0]}, i.e. operand zero-extended to DATA_W.
- MAR with hmar=0: holds; sel_ir is don't-care.
- bus_dir = MAR, registered, with one-cycle load latency.
- Simultaneous ena_ir=1, hmar=1, sel_ir=1: MAR takes the IR operand value from before this edge. IR and MAR update in the same edge. No forwarding.
- Simultaneous ena_ir=1, hmar=1, sel_ir=0: both registers capture the same busC value.
- Reset asserted mid-operation overrides any pending load. Loads are ignored while rst is low.
- No X propagation: every register has a defined reset value.

Optional Feature:
- Macro MAR_IR_INC_EN.
- When defined:
  - Adds input inc_mar (1 bit).
  - On a rising edge with hmar=0 and inc_mar=1, MAR<=MAR+1, modulo 2^DATA_W (0xFF wraps to 0x00).
  - hmar=1 has priority over inc_mar.
- When undefined: no inc_mar port; MAR changes only on hmar.

Decomposition:
- Package mar_ir_pkg:
  - DATA_W and OPCODE_W defaults.
  - Derived OPERAND_W.
  - Enum/localparam for sel_ir encoding: SEL_BUSC=0, SEL_IR=1.
- One generic sub-module, mar_ir_reg: an enabled DATA_W register with async active-low clear. Instantiated once for IR and once for MAR. MAR source mux and optional incrementer live in the top.

Test Plan:
1. Power-up: rst low, all inputs 0 -> opcode=5'b00000, bus_dir=8'h00 with no clock edge needed.
2. IR hold: rst high, busC=8'hAA, ena_ir=1 for one edge -> opcode=5'b10101. Then ena_ir=0, busC=8'hF0 -> opcode stays 5'b10101.
3. MAR from bus: busC=8'hF0, sel_ir=0, hmar=1 for one edge -> bus_dir=8'hF0. Then hmar=0, busC changes -> bus_dir holds 8'hF0.
4. MAR from IR: IR=8'hAA, sel_ir=1, hmar=1 -> bus_dir=8'h02. With ena_ir=1, busC=8'h1F on the same edge -> bus_dir=8'h02 and opcode=5'b00011.
5. Async reset: rst driven low mid-cycle (between edges) with IR=8'hAA, MAR=8'hF0 -> opcode=0, bus_dir=0 immediately. ena_ir/hmar held high during reset -> no load.
6. (MAR_IR_INC_EN) MAR=8'hFF, inc_mar=1, hmar=0 -> bus_dir=8'h00. Then hmar=1, inc_mar=1, busC=8'h40, sel_ir=0 -> bus_dir=8'h40.

Source files
------------

// File: rtl/mar_ir_pkg.sv
// Shared constants and encodings for the MAR/IR address-path front end.
package mar_ir_pkg;

   localparam int unsigned DEF_DATA_W    = 8;
   localparam int unsigned DEF_OPCODE_W  = 5;
   localparam int unsigned DEF_OPERAND_W = DEF_DATA_W - DEF_OPCODE_W;

   // MAR source select encoding
   typedef enum logic {
      SEL_BUSC = 1'b0,
      SEL_IR   = 1'b1
   } sel_e;

endpackage

// File: rtl/mar_ir_reg.sv
// Generic enabled register with asynchronous active-low clear.
module mar_ir_reg
   import mar_ir_pkg::*;
#(
   parameter int unsigned W = DEF_DATA_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/mar_ir_unit.sv
// Instruction register and memory address register feeding the address bus.
// Optional MAR auto-increment is enabled by defining MAR_IR_INC_EN.
module mar_ir_unit
   import mar_ir_pkg::*;
#(
   parameter int unsigned DATA_W   = DEF_DATA_W,
   parameter int unsigned OPCODE_W = DEF_OPCODE_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ena_ir,
   input  logic                sel_ir,
   input  logic                hmar,
`ifdef MAR_IR_INC_EN
   input  logic                inc_mar,
`endif
   input  logic [DATA_W-1:0]   busC,
   output logic [OPCODE_W-1:0] opcode,
   output logic [DATA_W-1:0]   bus_dir
);

   localparam int unsigned OPERAND_W = DATA_W - OPCODE_W;

   logic [DATA_W-1:0] ir_q;
   logic [DATA_W-1:0] mar_q;
   logic [DATA_W-1:0] mar_d;
   logic              mar_en;

   // MAR source: the operand comes from the IR value held before this edge
   always_comb begin
      mar_en = hmar;
      mar_d  = busC;
      if (sel_e'(sel_ir) == SEL_IR) begin
         mar_d = DATA_W'(ir_q[OPERAND_W-1:0]);
      end
`ifdef MAR_IR_INC_EN
      if (!hmar && inc_mar) begin
         mar_en = 1'b1;
         mar_d  = mar_q + DATA_W'(1);
      end
`endif
   end

   mar_ir_reg #(.W(DATA_W)) u_ir (
      .clk (clk),
      .rst (rst),
      .en  (ena_ir),
      .d   (busC),
      .q   (ir_q)
   );

   mar_ir_reg #(.W(DATA_W)) u_mar (
      .clk (clk),
      .rst (rst),
      .en  (mar_en),
      .d   (mar_d),
      .q   (mar_q)
   );

   assign opcode  = ir_q[DATA_W-1 -: OPCODE_W];
   assign bus_dir = mar_q;

endmodule

// File: tb/tb_mar_ir_unit.sv
// Self-checking bench for mar_ir_unit: directed plan steps plus randomized traffic.
module tb_mar_ir_unit;

   logic       clk    = 1'b0;
   logic       rst    = 1'b0;
   logic       ena_ir = 1'b0;
   logic       sel_ir = 1'b0;
   logic       hmar   = 1'b0;
   logic [7:0] busC   = 8'h00;
   logic [4:0] opcode;
   logic [7:0] bus_dir;
`ifdef MAR_IR_INC_EN
   logic       inc_mar = 1'b0;
`endif

   int vectors     = 0;
   int miscompares = 0;

   // Reference state kept as plain integers
   int m_ir  = 0;
   int m_mar = 0;

   always #5 clk = ~clk;

   mar_ir_unit dut (
      .clk     (clk),
      .rst     (rst),
      .ena_ir  (ena_ir),
      .sel_ir  (sel_ir),
      .hmar    (hmar),
`ifdef MAR_IR_INC_EN
      .inc_mar (inc_mar),
`endif
      .busC    (busC),
      .opcode  (opcode),
      .bus_dir (bus_dir)
   );

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_model(input string tag);
      check({tag, ".opcode"}, 8'(opcode), 8'(m_ir / 8));
      check({tag, ".bus_dir"}, bus_dir, 8'(m_mar));
   endtask

   // One rising edge, then advance the model from the inputs that edge saw
   task automatic clock_step();
      int  old_ir;
      bit  inc;
      inc = 1'b0;
`ifdef MAR_IR_INC_EN
      inc = inc_mar;
`endif
      @(posedge clk);
      old_ir = m_ir;
      if (!rst) begin
         m_ir  = 0;
         m_mar = 0;
      end else begin
         if (ena_ir) m_ir = int'(busC);
         if (hmar) m_mar = sel_ir ? (old_ir % 8) : int'(busC);
         else if (inc) m_mar = (m_mar + 1) % 256;
      end
      #1;
   endtask

   initial begin
      // Power-up: outputs cleared with no clock edge
      #2;
      check("powerup.opcode", 8'(opcode), 8'h00);
      check("powerup.bus_dir", bus_dir, 8'h00);

      // IR load then hold
      @(posedge clk); #1;
      rst = 1'b1;
      busC = 8'hAA; ena_ir = 1'b1;
      clock_step();
      check("ir_load.opcode", 8'(opcode), 8'h15);
      ena_ir = 1'b0; busC = 8'hF0;
      clock_step();
      check("ir_hold.opcode", 8'(opcode), 8'h15);

      // MAR from bus, then hold
      sel_ir = 1'b0; hmar = 1'b1;
      clock_step();
      check("mar_bus.bus_dir", bus_dir, 8'hF0);
      hmar = 1'b0; busC = 8'h3C;
      clock_step();
      check("mar_hold.bus_dir", bus_dir, 8'hF0);

      // MAR from IR operand with simultaneous IR load
      sel_ir = 1'b1; hmar = 1'b1; ena_ir = 1'b1; busC = 8'h1F;
      clock_step();
      check("mar_ir.bus_dir", bus_dir, 8'h02);
      check("mar_ir.opcode", 8'(opcode), 8'h03);

      // Same-edge load from busC into both registers
      sel_ir = 1'b0; busC = 8'h6B;
      clock_step();
      check("both_bus", bus_dir, 8'h6B);
      check_model("both_bus_model");

      // Prepare IR=AA, MAR=F0 then assert reset between edges
      ena_ir = 1'b1; hmar = 1'b0; busC = 8'hAA;
      clock_step();
      ena_ir = 1'b0; hmar = 1'b1; sel_ir = 1'b0; busC = 8'hF0;
      clock_step();
      check_model("pre_reset");
      ena_ir = 1'b1; hmar = 1'b1; busC = 8'h55;
      #3;
      rst = 1'b0;
      m_ir = 0; m_mar = 0;
      #1;
      check("async_rst.opcode", 8'(opcode), 8'h00);
      check("async_rst.bus_dir", bus_dir, 8'h00);
      clock_step();
      clock_step();
      check("rst_held.opcode", 8'(opcode), 8'h00);
      check("rst_held.bus_dir", bus_dir, 8'h00);
      rst = 1'b1; ena_ir = 1'b0; hmar = 1'b0;
      clock_step();
      check_model("post_reset");

      // Randomized traffic against the reference model
      for (int i = 0; i < 300; i++) begin
         ena_ir = 1'($urandom);
         hmar   = 1'($urandom);
         sel_ir = 1'($urandom);
         busC   = 8'($urandom);
`ifdef MAR_IR_INC_EN
         inc_mar = 1'($urandom);
`endif
         clock_step();
         check_model("random");
      end
      ena_ir = 1'b0; hmar = 1'b0;

`ifdef MAR_IR_INC_EN
      // Increment wrap and load priority over increment
      inc_mar = 1'b0; hmar = 1'b1; sel_ir = 1'b0; busC = 8'hFF;
      clock_step();
      check("inc_pre.bus_dir", bus_dir, 8'hFF);
      hmar = 1'b0; inc_mar = 1'b1;
      clock_step();
      check("inc_wrap.bus_dir", bus_dir, 8'h00);
      hmar = 1'b1; busC = 8'h40;
      clock_step();
      check("inc_prio.bus_dir", bus_dir, 8'h40);
      check_model("inc_model");
      inc_mar = 1'b0; hmar = 1'b0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
